// File: rtl/afifo_read_unpacker.sv
// Read-side unpacker: pops IN_WIDTH-bit words from a show-ahead async FIFO and emits
// RATIO OUT_WIDTH-bit beats per word. Define AFIFO_UNPACK_MSB_FIRST_EN for MSB-first beat order.
module afifo_read_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 read_clk,
  input  logic                 reset_rsync,
  input  logic [IN_WIDTH-1:0]  fifo_read_data,
  input  logic                 fifo_empty,
  output logic                 fifo_read_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] word_count
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * OUT_WIDTH != IN_WIDTH) begin : g_bad_ratio
      $error("afifo_read_unpacker: IN_WIDTH/OUT_WIDTH must be an integer power of two >= 2");
    end
  endgenerate

  // state | meaning
  // IDLE  | holding register empty, waiting for a FIFO word
  // BUSY  | holding register full, emitting beats of word_buf_q
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IN_WIDTH-1:0]    word_buf_q, word_buf_d;
  logic [IDX_W-1:0]       beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;
  logic                   accept;
  logic                   last_accept;

  always_ff @(posedge read_clk or posedge reset_rsync) begin
    if (reset_rsync) begin
      state_q      <= IDLE;
      word_buf_q   <= '0;
      beat_idx_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      word_buf_q   <= word_buf_d;
      beat_idx_q   <= beat_idx_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_buf_d   = word_buf_q;
    beat_idx_d   = beat_idx_q;
    word_count_d = word_count_q;

    accept       = (state_q == BUSY) && out_ready;
    last_accept  = accept && (beat_idx_q == LAST_IDX);
    // The pop on the final beat refills the buffer in the same edge, so words stream gap-free.
    fifo_read_en = !reset_rsync && !fifo_empty && ((state_q == IDLE) || last_accept);

    if (fifo_read_en) begin
      word_buf_d = fifo_read_data;
      state_d    = BUSY;
      beat_idx_d = '0;
    end else if (accept) begin
      if (beat_idx_q != LAST_IDX) begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end else begin
        state_d = IDLE;
      end
    end

    if (last_accept && (word_count_q != {CNT_WIDTH{1'b1}})) begin
      word_count_d = word_count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (beat_idx_q == IDX_W'(k)) begin
`ifdef AFIFO_UNPACK_MSB_FIRST_EN
        out_data = word_buf_q[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
        out_data = word_buf_q[k*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  assign out_valid  = (state_q == BUSY);
  assign out_last   = (state_q == BUSY) && (beat_idx_q == LAST_IDX);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_afifo_read_unpacker.sv
// Scoreboard bench for afifo_read_unpacker: FIFO model feeds words, expected beats are queued
// at push time and a negedge monitor checks every accepted beat plus the stream timing rules.
module tb_afifo_read_unpacker;
  localparam int IW = 32;
  localparam int OW = 8;
  localparam int CW = 16;
  localparam int R  = IW / OW;

  logic          read_clk = 1'b0;
  logic          reset_rsync;
  logic [IW-1:0] fifo_read_data;
  logic          fifo_empty;
  logic          fifo_read_en;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] word_count;

  afifo_read_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .read_clk       (read_clk),
    .reset_rsync    (reset_rsync),
    .fifo_read_data (fifo_read_data),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .word_count     (word_count)
  );

  always #5 read_clk = ~read_clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic [IW-1:0] tb_fifo[$];
  beat_t         exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            pop_count = 0;
  int            model_cnt = 0;
  logic          pop_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] beat_of(input logic [IW-1:0] w, input int k);
    logic [IW-1:0] s;
`ifdef AFIFO_UNPACK_MSB_FIRST_EN
    s = w >> (OW * (R - 1 - k));
`else
    s = w >> (OW * k);
`endif
    return s[OW-1:0];
  endfunction

  task automatic drive_fifo();
    fifo_empty     = (tb_fifo.size() == 0);
    fifo_read_data = (tb_fifo.size() != 0) ? tb_fifo[0] : IW'($urandom);
  endtask

  task automatic push_word(input logic [IW-1:0] w);
    beat_t b;
    tb_fifo.push_back(w);
    for (int k = 0; k < R; k++) begin
      b.data = beat_of(w, k);
      b.last = (k == R - 1);
      exp_q.push_back(b);
    end
    drive_fifo();
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
    if (pop_pending && tb_fifo.size() != 0) void'(tb_fifo.pop_front());
    pop_pending = 1'b0;
    drive_fifo();
  endtask

  // Monitor: sampled mid-cycle, checks beats against the scoreboard and the timing rules.
  logic          have_prev = 1'b0;
  logic          prev_valid, prev_ready, prev_last, prev_empty;
  logic [OW-1:0] prev_data;

  always @(negedge read_clk) begin
    if (reset_rsync) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_read_en", 32'(fifo_read_en), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      model_cnt   = 0;
      have_prev   = 1'b0;
      pop_pending = 1'b0;
    end else begin
      chk("word_count", 32'(word_count), 32'(model_cnt));
      if (fifo_read_en && fifo_empty) chk("read_en_while_empty", 32'd1, 32'd0);
      chk("read_en_rule", 32'(fifo_read_en),
          32'(!fifo_empty && (!out_valid || (out_ready && out_last))));
      if (have_prev) begin
        if (prev_valid && !prev_ready) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_data));
          chk("hold_last", 32'(out_last), 32'(prev_last));
        end else if (prev_valid && !prev_last) begin
          chk("no_bubble_in_word", 32'(out_valid), 32'd1);
        end else begin
          chk("refill_valid", 32'(out_valid), 32'(!prev_empty));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
          if (e.last && model_cnt < (1 << CW) - 1) model_cnt++;
        end
      end
      pop_pending = fifo_read_en;
      if (fifo_read_en) pop_count++;
      have_prev  = 1'b1;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_last  = out_last;
      prev_data  = out_data;
      prev_empty = fifo_empty;
    end
  end

  initial begin
    int base;
    int guard;
    reset_rsync = 1'b1;
    out_ready   = 1'b0;
    drive_fifo();
    tick();
    tick();

    // Reset held with a word waiting in the FIFO.
    push_word(32'hA1B2C3D4);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_read_en", 32'(fifo_read_en), 32'd0);
    chk("reset_word_count", 32'(word_count), 32'd0);
    tick();

    // Single word, continuous ready.
    base = pop_count;
    reset_rsync = 1'b0;
    out_ready   = 1'b1;
    repeat (8) tick();
    chk("single_pops", 32'(pop_count - base), 32'd1);
    chk("single_word_count", 32'(word_count), 32'd1);

    // Back-to-back words.
    base = pop_count;
    push_word(32'h11223344);
    push_word(32'h55667788);
    repeat (12) tick();
    chk("b2b_pops", 32'(pop_count - base), 32'd2);
    chk("b2b_word_count", 32'(word_count), 32'd3);

    // Backpressure on the second beat.
    push_word(32'hA1B2C3D4);
    tick();
    tick();
    out_ready = 1'b0;
    base = pop_count;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", 32'(out_data), 32'(beat_of(32'hA1B2C3D4, 1)));
      chk("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    chk("bp_no_pop", 32'(pop_count - base), 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("bp_word_count", 32'(word_count), 32'd4);

    // Reset mid-word after two beats accepted.
    push_word(32'hA1B2C3D4);
    tick();
    tick();
    tick();
    #2;
    reset_rsync = 1'b1;
    exp_q.delete();
    tb_fifo.delete();
    pop_pending = 1'b0;
    drive_fifo();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_word_count", 32'(word_count), 32'd0);
    chk("midrst_read_en", 32'(fifo_read_en), 32'd0);
    tick();
    reset_rsync = 1'b0;
    push_word(32'hCAFEF00D);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_first_beat", 32'(out_data), 32'(beat_of(32'hCAFEF00D, 0)));
    repeat (6) tick();

    // Random traffic with random backpressure and FIFO gaps.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (tb_fifo.size() < 3 && $urandom_range(0, 2) == 0) push_word(IW'($urandom));
      tick();
    end

    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || tb_fifo.size() != 0) && guard < 200) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 32'(guard < 200), 32'd1);
    repeat (3) tick();
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_word_count", 32'(word_count), 32'(model_cnt));
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
